// File: rtl/nonce_result_arbiter.sv
// Round-robin collector of golden-nonce results from NUM_CORES miner pipes into a
// small FIFO read one entry at a time by the host; counts results lost to overwrite.

module nonce_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_golden,
  input  logic [31:0] i_nonce2,
  input  logic [31:0] i_hash2,
  input  logic        i_grant,
  output logic [31:0] o_golden,
  output logic [31:0] o_nonce2,
  output logic [31:0] o_hash2,
  output logic        o_pending,
  output logic        o_lost
);
  logic [31:0] r_last, r_g, r_n, r_h;
  logic        r_pend;
  logic        w_det;

  assign w_det     = (i_golden != r_last);
  // A grant in the same cycle drains the old result, so reloading is not a loss.
  assign o_lost    = w_det && r_pend && !i_grant;
  assign o_golden  = r_g;
  assign o_nonce2  = r_n;
  assign o_hash2   = r_h;
  assign o_pending = r_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= '0;
      r_g    <= '0;
      r_n    <= '0;
      r_h    <= '0;
      r_pend <= 1'b0;
    end else begin
      r_last <= i_golden;
      if (w_det) begin
        r_g    <= i_golden;
        r_n    <= i_nonce2;
        r_h    <= i_hash2;
        r_pend <= 1'b1;
      end else if (i_grant) begin
        r_pend <= 1'b0;
      end
    end
  end
endmodule

module nonce_result_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*NUM_CORES-1:0] golden_nonce,
  input  logic [32*NUM_CORES-1:0] nonce2,
  input  logic [32*NUM_CORES-1:0] hash2,
  input  logic                    rd_ack,
  output logic                    out_valid,
  output logic [31:0]             out_golden,
  output logic [31:0]             out_nonce2,
  output logic [31:0]             out_hash2,
  output logic [3:0]              out_core,
  output logic [7:0]              lost_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Slot views padded to 16 so a 4-bit core index selects without width games.
  logic [15:0]           w_pend;
  logic [15:0][31:0]     w_sg, w_sn, w_sh;
  logic [NUM_CORES-1:0]  w_lost;
  logic [NUM_CORES-1:0]  w_gnt;

  logic                  w_gnt_vld;
  logic [3:0]            w_gnt_idx;
  logic [4:0]            w_try;
  logic [4:0]            w_nloss;
  logic [8:0]            w_lsum;
  logic                  w_push, w_pop;

  logic [3:0]                  r_rr;
  logic [7:0]                  r_lost;
  logic [AW-1:0]               r_wp, r_rp;
  logic [AW:0]                 r_count;
  logic [FIFO_DEPTH-1:0][31:0] r_fg, r_fn, r_fh;
  logic [FIFO_DEPTH-1:0][3:0]  r_fc;

  generate
    for (genvar i = 0; i < 16; i++) begin : g_core
      if (i < NUM_CORES) begin : g_on
        assign w_gnt[i] = w_gnt_vld && (w_gnt_idx == 4'(i));
        nonce_slot u_slot (
          .clk       (clk),
          .reset     (reset),
          .i_golden  (golden_nonce[32*i +: 32]),
          .i_nonce2  (nonce2[32*i +: 32]),
          .i_hash2   (hash2[32*i +: 32]),
          .i_grant   (w_gnt[i]),
          .o_golden  (w_sg[i]),
          .o_nonce2  (w_sn[i]),
          .o_hash2   (w_sh[i]),
          .o_pending (w_pend[i]),
          .o_lost    (w_lost[i])
        );
      end else begin : g_off
        assign w_sg[i]   = '0;
        assign w_sn[i]   = '0;
        assign w_sh[i]   = '0;
        assign w_pend[i] = 1'b0;
      end
    end
  endgenerate

  // First pending slot at or after rr, wrapping; blocked while the FIFO is full.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_try     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_try = {1'b0, r_rr} + 5'(k);
      if (w_try >= 5'(NUM_CORES)) w_try = w_try - 5'(NUM_CORES);
      if (!w_gnt_vld && !r_count[AW] && w_pend[w_try[3:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_try[3:0];
      end
    end
  end

  always_comb begin
    w_nloss = '0;
    for (int i = 0; i < NUM_CORES; i++) w_nloss = w_nloss + 5'(w_lost[i]);
    w_lsum = {1'b0, r_lost} + {4'b0, w_nloss};
  end

  assign w_push = w_gnt_vld;
  assign w_pop  = rd_ack && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr    <= '0;
      r_lost  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_fg    <= '0;
      r_fn    <= '0;
      r_fh    <= '0;
      r_fc    <= '0;
    end else begin
      if (w_push) begin
        r_fg[r_wp] <= w_sg[w_gnt_idx];
        r_fn[r_wp] <= w_sn[w_gnt_idx];
        r_fh[r_wp] <= w_sh[w_gnt_idx];
        r_fc[r_wp] <= w_gnt_idx;
        r_wp       <= r_wp + AW'(1);
        r_rr       <= (w_gnt_idx == 4'(NUM_CORES-1)) ? 4'd0 : w_gnt_idx + 4'd1;
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_lost <= w_lsum[8] ? 8'hFF : w_lsum[7:0];
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_golden = r_fg[r_rp];
  assign out_nonce2 = r_fn[r_rp];
  assign out_hash2  = r_fh[r_rp];
  assign out_core   = r_fc[r_rp];
  assign lost_count = r_lost;
endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Randomized and directed bench for nonce_result_arbiter against a queue-based model.
module tb_nonce_result_arbiter;
  localparam int NC = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_ack = 1'b0;
  logic [32*NC-1:0] golden_nonce, nonce2, hash2;
  logic out_valid;
  logic [31:0] out_golden, out_nonce2, out_hash2;
  logic [3:0] out_core;
  logic [7:0] lost_count;

  logic [31:0] tg [NC];
  logic [31:0] tn [NC];
  logic [31:0] th [NC];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    golden_nonce = '0; nonce2 = '0; hash2 = '0;
    for (int c = 0; c < NC; c++) begin
      golden_nonce[32*c +: 32] = tg[c];
      nonce2[32*c +: 32]       = tn[c];
      hash2[32*c +: 32]        = th[c];
    end
  end

  nonce_result_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .golden_nonce(golden_nonce), .nonce2(nonce2), .hash2(hash2),
    .rd_ack(rd_ack), .out_valid(out_valid), .out_golden(out_golden), .out_nonce2(out_nonce2),
    .out_hash2(out_hash2), .out_core(out_core), .lost_count(lost_count)
  );

  // Head fields only matter while something is queued.
  logic [108:0] obs;
  assign obs = out_valid ? {1'b1, out_golden, out_nonce2, out_hash2, out_core, lost_count}
                         : {1'b0, 100'd0, lost_count};

  typedef struct { logic [31:0] g, n, h; logic [3:0] c; } ent_t;
  ent_t mq[$];
  ent_t mslot [NC];
  bit   mpend [NC];
  logic [31:0] mlast [NC];
  int   mrr, mlost;

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < NC; c++) begin
      mpend[c] = 0; mlast[c] = '0; mslot[c] = '{g: '0, n: '0, h: '0, c: '0};
    end
    mrr = 0; mlost = 0;
  endtask

  task automatic model_edge(input bit ack);
    int gi = -1;
    ent_t pushed;
    pushed = '{g: '0, n: '0, h: '0, c: '0};
    if (mq.size() < FD)
      for (int k = 0; k < NC; k++)
        if (gi < 0 && mpend[(mrr + k) % NC]) gi = (mrr + k) % NC;
    if (gi >= 0) begin
      pushed = mslot[gi]; mpend[gi] = 0; mrr = (gi + 1) % NC;
    end
    for (int c = 0; c < NC; c++) begin
      if (tg[c] != mlast[c]) begin
        if (mpend[c]) mlost = (mlost < 255) ? mlost + 1 : 255;
        mslot[c] = '{g: tg[c], n: tn[c], h: th[c], c: 4'(c)};
        mpend[c] = 1;
      end
      mlast[c] = tg[c];
    end
    if (ack && mq.size() > 0) void'(mq.pop_front());
    if (gi >= 0) mq.push_back(pushed);
  endtask

  function automatic logic [108:0] exp_vec();
    if (mq.size() == 0) return {1'b0, 100'd0, 8'(mlost)};
    return {1'b1, mq[0].g, mq[0].n, mq[0].h, mq[0].c, 8'(mlost)};
  endfunction

  task automatic step(input bit ack);
    rd_ack = ack;
    model_edge(ack);
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < NC; c++) begin tg[c] = '0; tn[c] = '0; th[c] = '0; end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < NC; c++) begin tg[c] = '0; tn[c] = '0; th[c] = '0; end
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if ({out_golden, out_nonce2, out_hash2, out_core, lost_count} !== 108'd0) begin
      bad++; $display("FAIL reset_fields got=%h exp=0", {out_golden, out_nonce2, out_hash2, out_core, lost_count}); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [108:0] e;
    do_reset();
    tg[0] = 32'h12345678; tn[0] = 32'hA; th[0] = 32'hB;
    step(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", out_valid); end
    step(0);
    e = {1'b1, 32'h12345678, 32'hA, 32'hB, 4'd0, 8'd0};
    total++; if (obs !== e) begin bad++; $display("FAIL single_head got=%h exp=%h", obs, e); end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL single_model got=%h exp=%h", obs, exp_vec()); end
    step(1);
    total++; if ({out_valid, lost_count} !== 9'd0) begin bad++; $display("FAIL single_pop got=%h exp=0", {out_valid, lost_count}); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      tg[0] = 32'h100 + r; tn[0] = 32'h10; th[0] = 32'h11;
      tg[1] = 32'h200 + r; tn[1] = 32'h20; th[1] = 32'h21;
      step(0); step(0);
      total++; if (out_core !== 4'd0 || out_golden !== 32'h100 + r) begin
        bad++; $display("FAIL fair_first_%0d got=%h/%h exp=0/%h", r, out_core, out_golden, 32'h100 + r); end
      step(0);
      step(1);
      total++; if (out_core !== 4'd1 || out_golden !== 32'h200 + r) begin
        bad++; $display("FAIL fair_second_%0d got=%h/%h exp=1/%h", r, out_core, out_golden, 32'h200 + r); end
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL fair_model_%0d got=%h exp=%h", r, obs, exp_vec()); end
      step(1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] order [4];
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      tg[0] = 32'hC000_0000 + v; tn[0] = v; th[0] = ~v;
      step(0); step(0);
    end
    total++; if (obs !== exp_vec() || lost_count !== 8'd0 || out_golden !== 32'hC000_0001) begin
      bad++; $display("FAIL ovf_full got=%h exp=%h", obs, exp_vec()); end
    tg[0] = 32'hC000_0006; step(0);
    total++; if (lost_count !== 8'd1) begin bad++; $display("FAIL ovf_lost1 got=%0d exp=1", lost_count); end
    step(0);
    tg[0] = 32'hC000_0007; step(0);
    total++; if (lost_count !== 8'd2) begin bad++; $display("FAIL ovf_lost2 got=%0d exp=2", lost_count); end
    step(0);
    step(1);  // pop while full: the grant waits one more cycle
    step(0);
    order = '{32'hC000_0002, 32'hC000_0003, 32'hC000_0004, 32'hC000_0007};
    for (int i = 0; i < 4; i++) begin
      total++; if (obs !== exp_vec() || out_golden !== order[i] || !out_valid) begin
        bad++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, out_golden, order[i]); end
      step(1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_pushpop();
    do_reset();
    tg[0] = 32'hA1; step(0);
    tg[0] = 32'hA2; step(0);
    tg[0] = 32'hA3; step(0);
    step(1);  // push A3 and pop A1 on the same edge
    total++; if (out_golden !== 32'hA2 || obs !== exp_vec()) begin
      bad++; $display("FAIL pp_head got=%h exp=000000a2", out_golden); end
    step(1);
    total++; if (out_golden !== 32'hA3 || !out_valid) begin bad++; $display("FAIL pp_next got=%h exp=000000a3", out_golden); end
    step(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_recapture();
    do_reset();
    tg[1] = 32'hB1; tn[1] = 32'h1; step(0);
    tg[1] = 32'hB2; tn[1] = 32'h2; step(0);
    step(0);
    total++; if (out_golden !== 32'hB1 || out_core !== 4'd1 || lost_count !== 8'd0) begin
      bad++; $display("FAIL recap_first got=%h/%h/%0d exp=b1/1/0", out_golden, out_core, lost_count); end
    step(1);
    total++; if (out_golden !== 32'hB2 || out_nonce2 !== 32'h2 || obs !== exp_vec()) begin
      bad++; $display("FAIL recap_second got=%h exp=000000b2", out_golden); end
    step(1);
  endtask

  task automatic test_reset_mid();
    logic [108:0] e;
    do_reset();
    tg[0] = 32'hD1; step(0);
    tg[0] = 32'hD2; step(0);
    tg[0] = 32'hD3; step(0);
    step(0);
    total++; if (obs !== exp_vec() || mq.size() != 3) begin bad++; $display("FAIL mid_queued got=%h exp=%h", obs, exp_vec()); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0 || out_golden !== 32'd0) begin
      bad++; $display("FAIL mid_async got=%b/%h exp=0/0", out_valid, out_golden); end
    for (int c = 0; c < NC; c++) begin tg[c] = '0; tn[c] = '0; th[c] = '0; end
    @(posedge clk); #1;
    reset = 1'b0;
    tg[0] = 32'h1; step(0); step(0);
    e = {1'b1, 32'h1, 32'h0, 32'h0, 4'd0, 8'd0};
    total++; if (obs !== e) begin bad++; $display("FAIL mid_after got=%h exp=%h", obs, e); end
    step(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(2) == 0) begin tg[c] = $urandom; tn[c] = $urandom; th[c] = $urandom; end
      step(bit'($urandom_range(1)));
      total++;
      if (obs !== exp_vec()) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL random_c%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_pushpop();
    test_recapture();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
